// File: rtl/period_frame_packetizer_if.sv
// rtl/period_frame_packetizer_if.sv - byte stream bus between the period packetizer and the output pins
interface period_frame_packetizer_if;
    logic [7:0] data_out;
    logic       data_valid;
    logic       data_ready;
    logic       frame_start;
    logic       frame_end;

    modport master (output data_out, data_valid, frame_start, frame_end, input data_ready);
    modport slave  (input data_out, data_valid, frame_start, frame_end, output data_ready);
endinterface

// File: rtl/period_frame_packetizer.sv
// rtl/period_frame_packetizer.sv - snapshots CHANNELS period values and streams them as one framed byte packet
// Optional trailing XOR checksum byte: define PERIOD_FRAME_CHECKSUM_EN
module period_frame_packetizer #(
    parameter int         CHANNELS     = 8,
    parameter int         COUNTER_BITS = 15,
    parameter logic [7:0] SYNC_BYTE    = 8'hA5
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [CHANNELS*COUNTER_BITS-1:0] period_in,
    input  logic [CHANNELS-1:0]              channel_mask,
    input  logic                             start,
    output logic                             busy,
    output logic [7:0]                       drop_count,
    period_frame_packetizer_if.master        stream
);
    localparam int BYTES = (COUNTER_BITS + 7) / 8;
    localparam int PW    = BYTES * 8;
    localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int BI_W  = (BYTES > 1) ? $clog2(BYTES) : 1;

`ifdef PERIOD_FRAME_CHECKSUM_EN
    localparam bit CSUM_EN = 1'b1;
    typedef enum logic [2:0] {IDLE, SYNC, COUNT, CHID, DATA, CSUM} state_t;
`else
    localparam bit CSUM_EN = 1'b0;
    typedef enum logic [2:0] {IDLE, SYNC, COUNT, CHID, DATA} state_t;
`endif

    state_t              state;
    logic [PW-1:0]       period_q [CHANNELS];
    logic [CHANNELS-1:0] mask_q;
    logic [CH_W-1:0]     cur_ch;
    logic [CH_W-1:0]     first_ch;
    logic [CH_W-1:0]     next_ch;
    logic                has_next;
    logic [BI_W-1:0]     byte_idx;
    logic [7:0]          pop;
    logic                consume;

    assign consume = stream.data_valid && stream.data_ready;

    // Descending scan so the lowest qualifying index is the one left standing
    always_comb begin
        pop      = '0;
        has_next = 1'b0;
        next_ch  = '0;
        first_ch = '0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            pop = pop + 8'(mask_q[i]);
            if (mask_q[i]) first_ch = CH_W'(i);
            if (mask_q[i] && (CH_W'(i) > cur_ch)) begin
                has_next = 1'b1;
                next_ch  = CH_W'(i);
            end
        end
    end

    function automatic logic [7:0] byte_of(input logic [CH_W-1:0] ch, input logic [BI_W-1:0] idx);
        return 8'(period_q[ch] >> (8 * idx));
    endfunction

`ifdef PERIOD_FRAME_CHECKSUM_EN
    // Accumulates every consumed byte after SYNC; the CSUM byte folds in the byte being consumed
    logic [7:0] csum;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                        csum <= '0;
        else if (state == IDLE)            csum <= '0;
        else if (consume && state != SYNC) csum <= csum ^ stream.data_out;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state              <= IDLE;
            stream.data_out    <= '0;
            stream.data_valid  <= 1'b0;
            stream.frame_start <= 1'b0;
            stream.frame_end   <= 1'b0;
            busy               <= 1'b0;
            drop_count         <= '0;
            mask_q             <= '0;
            cur_ch             <= '0;
            byte_idx           <= '0;
            for (int i = 0; i < CHANNELS; i++) period_q[i] <= '0;
        end else begin
            if (start && busy && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
            if (state == IDLE) begin
                if (start) begin
                    for (int i = 0; i < CHANNELS; i++)
                        period_q[i] <= PW'(period_in[i*COUNTER_BITS +: COUNTER_BITS]);
                    mask_q             <= channel_mask;
                    stream.data_out    <= SYNC_BYTE;
                    stream.data_valid  <= 1'b1;
                    stream.frame_start <= 1'b1;
                    stream.frame_end   <= 1'b0;
                    busy               <= 1'b1;
                    state              <= SYNC;
                end
            end else if (consume && stream.frame_end) begin
                state             <= IDLE;
                stream.data_out   <= '0;
                stream.data_valid <= 1'b0;
                stream.frame_end  <= 1'b0;
                busy              <= 1'b0;
            end else if (consume) begin
                stream.frame_start <= 1'b0;
                case (state)
                    SYNC: begin
                        stream.data_out  <= pop;
                        stream.frame_end <= !CSUM_EN && (pop == 8'd0);
                        state            <= COUNT;
                    end
                    COUNT: begin
                        if (pop != 8'd0) begin
                            stream.data_out <= 8'(first_ch);
                            cur_ch          <= first_ch;
                            state           <= CHID;
                        end
`ifdef PERIOD_FRAME_CHECKSUM_EN
                        else begin
                            stream.data_out  <= csum ^ stream.data_out;
                            stream.frame_end <= 1'b1;
                            state            <= CSUM;
                        end
`endif
                    end
                    CHID: begin
                        byte_idx         <= BI_W'(BYTES - 1);
                        stream.data_out  <= byte_of(cur_ch, BI_W'(BYTES - 1));
                        stream.frame_end <= !CSUM_EN && (BYTES == 1) && !has_next;
                        state            <= DATA;
                    end
                    DATA: begin
                        if (byte_idx != '0) begin
                            byte_idx         <= byte_idx - 1'b1;
                            stream.data_out  <= byte_of(cur_ch, byte_idx - 1'b1);
                            stream.frame_end <= !CSUM_EN && (byte_idx == BI_W'(1)) && !has_next;
                        end else if (has_next) begin
                            stream.data_out <= 8'(next_ch);
                            cur_ch          <= next_ch;
                            state           <= CHID;
                        end
`ifdef PERIOD_FRAME_CHECKSUM_EN
                        else begin
                            stream.data_out  <= csum ^ stream.data_out;
                            stream.frame_end <= 1'b1;
                            state            <= CSUM;
                        end
`endif
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_period_frame_packetizer.sv
// tb/tb_period_frame_packetizer.sv - directed self-checking bench for period_frame_packetizer
module tb_period_frame_packetizer;
    localparam int CHANNELS = 8;
    localparam int CB       = 15;

    logic                   clk          = 1'b0;
    logic                   rst_n        = 1'b0;
    logic [CHANNELS*CB-1:0] period_in    = '0;
    logic [CHANNELS-1:0]    channel_mask = '0;
    logic                   start        = 1'b0;
    logic                   busy;
    logic [7:0]             drop_count;
    int                     checks   = 0;
    int                     failures = 0;

    period_frame_packetizer_if bus ();

    period_frame_packetizer #(
        .CHANNELS(CHANNELS),
        .COUNTER_BITS(CB),
        .SYNC_BYTE(8'hA5)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .period_in(period_in),
        .channel_mask(channel_mask),
        .start(start),
        .busy(busy),
        .drop_count(drop_count),
        .stream(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_basic_periods();
        period_in = '0;
        period_in[0*CB +: CB] = 15'h1234;
        period_in[2*CB +: CB] = 15'h7FFF;
    endtask

    task automatic send_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called at a negedge with the frame already presenting its SYNC byte
    task automatic run_frame(input string tag, input int mode, input bit drops, input logic [7:0] exp[$]);
        logic [7:0] rx[$];
        logic [9:0] hold_vec;
        bit         held = 1'b0;
        bit         done = 1'b0;
        int         fs_n = 0;
        bit         fs_first = 1'b0;
        int         c = 0;
        while (!done && c < 400) begin
            bus.data_ready = (mode == 0) || (c % 3 == 0);
            start = drops && (c == 2 || c == 4 || c == 6);
            if (drops && c == 1) period_in = ~period_in;
            #1;
            if (held)
                check({tag, "/hold"}, {bus.data_valid, bus.frame_start, bus.frame_end, bus.data_out}, {1'b1, hold_vec});
            held     = bus.data_valid && !bus.data_ready;
            hold_vec = {bus.frame_start, bus.frame_end, bus.data_out};
            if (bus.data_valid && bus.data_ready) begin
                if (bus.frame_start) begin
                    fs_n++;
                    if (rx.size() == 0) fs_first = 1'b1;
                end
                rx.push_back(bus.data_out);
                if (bus.frame_end) done = 1'b1;
            end
            @(negedge clk);
            c++;
        end
        start = 1'b0;
        if (!done) check({tag, "/timeout"}, 32'd0, 32'd1);
        if (mode == 0) check({tag, "/cycles"}, c, exp.size());
        check({tag, "/len"}, rx.size(), exp.size());
        for (int i = 0; i < exp.size() && i < rx.size(); i++)
            check($sformatf("%s/byte%0d", tag, i), rx[i], exp[i]);
        check({tag, "/frame_start"}, {fs_n[7:0], 7'd0, fs_first}, {8'd1, 8'd1});
        check({tag, "/idle_after"}, {busy, bus.data_valid}, 2'b00);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] e[$];
        bus.data_ready = 1'b0;
        #12;
        check("reset_outputs", {busy, bus.data_valid, bus.frame_start, bus.frame_end, bus.data_out, drop_count},
              20'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic frame with a ready sink
        channel_mask = 8'h05;
        set_basic_periods();
        e = {8'hA5, 8'h02, 8'h00, 8'h12, 8'h34, 8'h02, 8'h7F, 8'hFF};
`ifdef PERIOD_FRAME_CHECKSUM_EN
        e.push_back(8'hA6);
`endif
        bus.data_ready = 1'b1;
        send_start();
        check("latency", {busy, bus.data_valid, bus.data_out}, {2'b11, 8'hA5});
        run_frame("basic", 0, 1'b0, e);

        // Backpressure pattern 1,0,0,1,0,0...
        send_start();
        run_frame("backpressure", 1, 1'b0, e);

        // Snapshot isolation and dropped starts
        check("drops_before", drop_count, 8'd0);
        send_start();
        run_frame("snapshot", 0, 1'b1, e);
        check("drops_three", drop_count, 8'd3);

        set_basic_periods();
        bus.data_ready = 1'b0;
        @(negedge clk);
        start = 1'b1;
        repeat (301) @(negedge clk);
        start = 1'b0;
        check("drops_saturate", drop_count, 8'hFF);
        check("busy_stalled", busy, 1'b1);
        run_frame("drain", 0, 1'b0, e);

        // Empty mask
        channel_mask = 8'h00;
        e = {8'hA5, 8'h00};
`ifdef PERIOD_FRAME_CHECKSUM_EN
        e.push_back(8'h00);
`endif
        send_start();
        run_frame("empty", 0, 1'b0, e);

        // Full mask, ch i = 15'h0101*i; XOR of count and data bytes works out to 08
        channel_mask = 8'hFF;
        for (int i = 0; i < CHANNELS; i++) period_in[i*CB +: CB] = 15'(15'h0101 * i);
        e = {8'hA5, 8'h08};
        for (int i = 0; i < CHANNELS; i++) begin
            e.push_back(8'(i));
            e.push_back(8'(i));
            e.push_back(8'(i));
        end
`ifdef PERIOD_FRAME_CHECKSUM_EN
        e.push_back(8'h08);
`endif
        send_start();
        run_frame("full", 0, 1'b0, e);

        // Reset during the first data byte of ch0
        channel_mask = 8'h05;
        set_basic_periods();
        e = {8'hA5, 8'h02, 8'h00, 8'h12, 8'h34, 8'h02, 8'h7F, 8'hFF};
`ifdef PERIOD_FRAME_CHECKSUM_EN
        e.push_back(8'hA6);
`endif
        bus.data_ready = 1'b1;
        send_start();
        repeat (3) @(negedge clk);
        check("pre_reset_byte", bus.data_out, 8'h12);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", {busy, bus.data_valid, bus.frame_start, bus.frame_end, bus.data_out, drop_count},
              20'h0);
        @(negedge clk);
        rst_n = 1'b1;
        send_start();
        run_frame("after_reset", 0, 1'b0, e);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
